regfile_dump_engine: RTL and testbench
======================================

// Module: regfile_dump_engine
// PURPOSE
//  Debug reader for the CPU register file. On a start pulse it walks registers 0..NUM_REGS-1
//  through one read port and serialises them onto a byte stream with a valid/ready handshake,
//  typically feeding the UART transmitter. Frame = header byte, 4 bytes per register MSB-first,
//  checksum byte. The CPU is held stalled via busy while the dump runs.
// PARAMETERS
//  NUM_REGS     32      registers dumped, index 0..NUM_REGS-1
//  ADDR_W       5       register address width
//  DATA_W       32      register width; fixed 4 bytes/word
//  HEADER_BYTE  8'hA5   first byte of every frame
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-low
//  start      in   1       begin dump; sampled only in IDLE
//  abort      in   1       cancel dump; any non-IDLE state
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse after checksum byte accepted
//  rf_read    out  1       register-file read enable
//  rf_addr    out  ADDR_W  register-file read address
//  rf_data    in   DATA_W  combinational read data, valid in the same cycle as rf_read
//  tx_data    out  8       stream byte
//  tx_valid   out  1       stream byte valid
//  tx_ready   in   1       sink accepts byte when tx_valid && tx_ready at posedge
// BEHAVIOUR
//  Reset values: state IDLE, busy 0, done 0, rf_read 0, rf_addr 0, tx_valid 0, tx_data 0,
//   internal idx 0, byte_cnt 0, csum 0, shift register 0.
//  Outputs are Moore, decoded from registered state only. No combinational path from
//   tx_ready or rf_data to any output.
//  States:
//   IDLE     start && !abort -> HEADER; clears idx, csum.
//   HEADER   tx_valid=1, tx_data=HEADER_BYTE; on handshake -> READ.
//   READ     one cycle; rf_read=1, rf_addr=idx; shreg<=rf_data, byte_cnt<=0; -> SEND.
//   SEND     tx_valid=1, tx_data=shreg[31:24]; on handshake: csum<=csum+byte (mod 256),
//            shreg<<=8, byte_cnt++. On the handshake with byte_cnt==3:
//            idx==NUM_REGS-1 -> CHECKSUM, else idx++ -> READ.
//   CHECKSUM tx_valid=1, tx_data=csum; on handshake -> DONE.
//   DONE     done=1 for one cycle -> IDLE.
//  Checksum covers the data bytes only (header excluded), as an 8-bit wrapping sum.
//  rf_read is 0 in every state except READ. rf_addr holds idx in all states.
//  Handshake: tx_data is stable while tx_valid && !tx_ready. tx_valid never drops without a
//   handshake, except on abort or reset.
//  abort: any non-IDLE state -> IDLE next cycle; tx_valid 0, done not pulsed.
//   A byte presented in the abort cycle is not counted in csum.
//  start while busy: ignored. start && abort in IDLE: abort wins, stay IDLE.
//  Latency with tx_ready held 1: start sampled at edge 0, first tx_valid at cycle 1, done at
//   cycle 163 (1 header + 32*(1+4) + 1 checksum + 1 done). 130 bytes per frame.
//  Async reset mid-dump: all outputs take reset values immediately, no completion.
// STRUCTURE
//  Package regfile_dump_pkg:
//   - dump_state_t enum {IDLE, HEADER, READ, SEND, CHECKSUM, DONE}
//   - BYTES_PER_WORD=4
//   - DEFAULT_HEADER=8'hA5
//  Single module, no sub-module. Shift register, counters and checksum are inline.
// TESTING
//  1 Reg k = k*32'h01010101, tx_ready=1, pulse start -> A5,00x4,01x4..1Fx4,C0; done at
//    cycle 163.
//  2 r0=0, r1..r31=FFFFFFFF -> 124 data bytes FF, checksum 0x84; rf_read high exactly 32
//    cycles.
//  3 Pattern from test 1 with tx_ready high 1 cycle in 3 -> identical 130-byte stream;
//    tx_data constant across every stall; no duplicate or dropped bytes.
//  4 abort during SEND of reg 10 byte 2 -> next cycle IDLE, busy 0, tx_valid 0, no done;
//    restart -> full clean frame, checksum C0.
//  5 start pulsed mid-dump -> ignored, frame unchanged. start+abort together in IDLE ->
//    busy stays 0.
//  6 rst low at reg 20 -> outputs reset asynchronously; after release, start -> complete
//    correct frame.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
package regfile_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        READ,
        SEND,
        CHECKSUM,
        DONE
    } dump_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/regfile_dump_engine.sv
// Walks the register file and streams header, each register MSB-first, then an
// 8-bit wrapping checksum of the data bytes, over a valid/ready byte interface.
module regfile_dump_engine
    import regfile_dump_pkg::*;
#(
    parameter int          NUM_REGS    = 32,
    parameter int          ADDR_W      = 5,
    parameter int          DATA_W      = 32,
    parameter logic [7:0]  HEADER_BYTE = DEFAULT_HEADER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rf_read,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    // Stream handshake: a byte moves when tx_valid && tx_ready at posedge; tx_data
    // holds while stalled and tx_valid only falls after a handshake, abort or reset.

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_byte_cnt;
    logic [7:0]        r_csum;
    logic [DATA_W-1:0] r_shreg;
    logic              r_busy;
    logic              r_done;
    logic              r_rf_read;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            r_shreg    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rf_read  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != IDLE)) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_rf_read  <= 1'b0;
                r_tx_valid <= 1'b0;
                r_tx_data  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && !abort) begin
                            r_state    <= HEADER;
                            r_idx      <= '0;
                            r_csum     <= '0;
                            r_busy     <= 1'b1;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= HEADER_BYTE;
                        end
                    end
                    HEADER: begin
                        if (tx_ready) begin
                            r_state    <= READ;
                            r_tx_valid <= 1'b0;
                            r_rf_read  <= 1'b1;
                        end
                    end
                    READ: begin
                        // Read data is combinational, so the first byte is known now.
                        r_shreg    <= rf_data;
                        r_byte_cnt <= '0;
                        r_rf_read  <= 1'b0;
                        r_state    <= SEND;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= rf_data[DATA_W-1 -: 8];
                    end
                    SEND: begin
                        if (tx_ready) begin
                            r_csum     <= r_csum + r_shreg[DATA_W-1 -: 8];
                            r_shreg    <= r_shreg << 8;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                                if (r_idx == ADDR_W'(NUM_REGS - 1)) begin
                                    r_state    <= CHECKSUM;
                                    r_tx_valid <= 1'b1;
                                    r_tx_data  <= r_csum + r_shreg[DATA_W-1 -: 8];
                                end else begin
                                    r_idx      <= r_idx + ADDR_W'(1);
                                    r_state    <= READ;
                                    r_rf_read  <= 1'b1;
                                    r_tx_valid <= 1'b0;
                                end
                            end else begin
                                r_tx_data <= r_shreg[DATA_W-9 -: 8];
                            end
                        end
                    end
                    CHECKSUM: begin
                        if (tx_ready) begin
                            r_state    <= DONE;
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rf_read  = r_rf_read;
    assign rf_addr  = r_idx;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Scoreboard bench for regfile_dump_engine: directed frames, stalls, abort, mid-dump reset.
module tb_regfile_dump_engine;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              tx_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              rf_read;
    logic              tx_valid;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [7:0]        tx_data;

    logic [DATA_W-1:0] rf_mem [NUM_REGS];
    assign rf_data = rf_mem[rf_addr];

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int done_cnt = 0;
    int rd_total = 0;
    int rd_idx   = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    regfile_dump_engine dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rf_read  (rf_read),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected byte on every accepted transfer, watches stalls and reads.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(tx_valid), 32'd1);
                check("stall_data_held", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            if (!busy) rd_idx = 0;
            if (rf_read) begin
                check("rf_addr_seq", 32'(rf_addr), 32'(rd_idx));
                rd_idx++;
                rd_total++;
            end
            if (done) done_cnt++;
            prev_stall = tx_valid && !tx_ready && !abort;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic load_ramp();
        for (int k = 0; k < NUM_REGS; k++) rf_mem[k] = 32'(k) * 32'h0101_0101;
    endtask

    task automatic load_ones();
        rf_mem[0] = '0;
        for (int k = 1; k < NUM_REGS; k++) rf_mem[k] = 32'hFFFF_FFFF;
    endtask

    task automatic push_ramp_frame();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NUM_REGS; k++)
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(k));
        exp_q.push_back(8'hC0);
    endtask

    task automatic push_ones_frame();
        exp_q.push_back(8'hA5);
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h00);
        for (int b = 0; b < 124; b++) exp_q.push_back(8'hFF);
        exp_q.push_back(8'h84);
    endtask

    // mode 0: tx_ready always high; mode 1: high one cycle in three.
    task automatic run_frame(input int mode, input int mid_start, output int done_cyc);
        done_cyc = 0;
        start    = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            tx_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            start    = (c == mid_start);
            @(negedge clk);
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        check("done_seen", 32'(done_cyc != 0), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int dc;
        int rd0;
        int dn0;

        load_ramp();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_read", 32'(rf_read), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Ramp pattern, sink always ready.
        push_ramp_frame();
        rd0 = rd_total; dn0 = done_cnt;
        run_frame(0, 0, dc);
        check("t1_done_cycle", 32'(dc), 32'd163);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_reads", 32'(rd_total - rd0), 32'd32);
        check("t1_done_once", 32'(done_cnt - dn0), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);

        // Zero then all-ones registers.
        load_ones();
        push_ones_frame();
        rd0 = rd_total;
        run_frame(0, 0, dc);
        check("t2_done_cycle", 32'(dc), 32'd163);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t2_reads", 32'(rd_total - rd0), 32'd32);

        // Back-pressure one cycle in three.
        load_ramp();
        push_ramp_frame();
        run_frame(1, 0, dc);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort while reg 10 byte 2 is presented (cycle 55 with ready held).
        for (int k = 0; k < 10; k++)
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(k));
        exp_q.push_front(8'hA5);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0A);
        dn0 = done_cnt;
        start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (54) @(posedge clk);
        #1;
        check("t4_busy_before", 32'(busy), 32'd1);
        check("t4_byte_before", 32'(tx_data), 32'h0A);
        abort = 1'b1; tx_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0; tx_ready = 1'b1;
        check("t4_abort_busy", 32'(busy), 32'd0);
        check("t4_abort_valid", 32'(tx_valid), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (200) @(posedge clk);
        #1;
        check("t4_no_done", 32'(done_cnt - dn0), 32'd0);
        push_ramp_frame();
        run_frame(0, 0, dc);
        check("t4_restart_done", 32'(dc), 32'd163);
        check("t4_restart_queue", 32'(exp_q.size()), 32'd0);

        // start pulsed mid-dump is ignored.
        push_ramp_frame();
        run_frame(0, 30, dc);
        check("t5_done_cycle", 32'(dc), 32'd163);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("t5_start_abort_busy", 32'(busy), 32'd0);
        check("t5_start_abort_valid", 32'(tx_valid), 32'd0);
        @(posedge clk); #1;
        check("t5_still_idle", 32'(busy), 32'd0);

        // Asynchronous reset while reg 20 is in flight.
        push_ramp_frame();
        dn0 = done_cnt;
        start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (102) @(posedge clk);
        #1;
        check("t6_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_tx_valid", 32'(tx_valid), 32'd0);
        check("t6_tx_data", 32'(tx_data), 32'd0);
        check("t6_rf_read", 32'(rf_read), 32'd0);
        check("t6_rf_addr", 32'(rf_addr), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_no_done", 32'(done_cnt - dn0), 32'd0);
        push_ramp_frame();
        run_frame(0, 0, dc);
        check("t6_after_done", 32'(dc), 32'd163);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
